// File: rtl/gen_debug_pkg.sv
// Shared types and helpers for the debug data sweep/capture logic.
package gen_debug_pkg;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2
  } sweep_state_e;

  // The debug mux registers its select and then its data, so the capture
  // point must sit at least three edges after a selector change.
  localparam int GEN_DEBUG_MIN_SETTLE = 3;

  // Advance a selector index, wrapping from options-1 back to 0.
  function automatic int unsigned next_sel(input int unsigned sel, input int unsigned options);
    if (sel + 1 >= options) begin
      return 0;
    end
    return sel + 1;
  endfunction

endpackage

// File: rtl/gen_debug_data_sweep_capture.sv
// Steps the multicycle debug mux selector through a programmed index range,
// waits for the mux path to settle, captures each slice and streams it out
// on a valid/ready interface tagged with its selector index.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no sweep running; data_sel holds its last value
// SETTLE | selector applied, counting cnt 0..SETTLE_CYCLES-1
// SEND   | captured word presented, m_valid held until m_ready
module gen_debug_data_sweep_capture
  import gen_debug_pkg::*;
#(
  parameter int DATA_SEL_OPTIONS   = 12,
  parameter int DATA_SEL_WIDTH     = $clog2(DATA_SEL_OPTIONS),
  parameter int OUT_DATA_BUS_WIDTH = 32,
  parameter int SETTLE_CYCLES      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [DATA_SEL_WIDTH-1:0]     first_sel,
  input  logic [DATA_SEL_WIDTH-1:0]     last_sel,
  input  logic [OUT_DATA_BUS_WIDTH-1:0] mux_data,
  output logic [DATA_SEL_WIDTH-1:0]     data_sel,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [OUT_DATA_BUS_WIDTH-1:0] m_data,
  output logic [DATA_SEL_WIDTH-1:0]     m_sel,
  output logic                          m_last,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  // One extra bit so the option count itself is representable even when
  // DATA_SEL_OPTIONS is a power of two.
  localparam logic [DATA_SEL_WIDTH:0] SEL_LIMIT = (DATA_SEL_WIDTH + 1)'(DATA_SEL_OPTIONS);

  if (SETTLE_CYCLES < GEN_DEBUG_MIN_SETTLE) begin : g_settle_check
    $error("SETTLE_CYCLES is shorter than the debug mux select-to-data latency");
  end

  sweep_state_e             state_q;
  sweep_state_e             state_d;
  logic [CNT_W-1:0]         cnt;
  logic [DATA_SEL_WIDTH-1:0] last_q;

  logic range_ok;
  logic load_start;
  logic reject_start;
  logic capture;
  logic xfer;

  assign range_ok = ({1'b0, first_sel} < SEL_LIMIT) && ({1'b0, last_sel} < SEL_LIMIT);
  assign busy     = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and per-edge action strobes; abort overrides all.
  always_comb begin
    state_d      = state_q;
    load_start   = 1'b0;
    reject_start = 1'b0;
    capture      = 1'b0;
    xfer         = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (range_ok) begin
              load_start = 1'b1;
              state_d    = SETTLE;
            end else begin
              reject_start = 1'b1;
            end
          end
        end
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            capture = 1'b1;
            state_d = SEND;
          end
        end
        SEND: begin
          if (m_valid && m_ready) begin
            xfer    = 1'b1;
            state_d = m_last ? IDLE : SETTLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Selector, settle counter, capture registers and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sel <= '0;
      last_q   <= '0;
      cnt      <= '0;
      m_data   <= '0;
      m_sel    <= '0;
      m_last   <= 1'b0;
      m_valid  <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (abort) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
        cnt     <= '0;
      end else begin
        if (reject_start) begin
          cfg_err <= 1'b1;
        end
        if (load_start) begin
          data_sel <= first_sel;
          last_q   <= last_sel;
          cnt      <= '0;
        end
        if ((state_q == SETTLE) && !capture) begin
          cnt <= cnt + CNT_W'(1);
        end
        if (capture) begin
          m_data  <= mux_data;
          m_sel   <= data_sel;
          m_last  <= (data_sel == last_q);
          m_valid <= 1'b1;
        end
        if (xfer) begin
          m_valid <= 1'b0;
          if (m_last) begin
            done <= 1'b1;
          end else begin
            data_sel <= DATA_SEL_WIDTH'(next_sel(32'(data_sel), unsigned'(DATA_SEL_OPTIONS)));
            cnt      <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gen_debug_data_sweep_capture.sv
// Directed and randomized sweeps against a two-register mux model, with
// expected words derived from the index range arithmetic.
module tb_gen_debug_data_sweep_capture;

  localparam int N      = 12;
  localparam int SW     = 4;
  localparam int SETTLE = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [SW-1:0] first_sel;
  logic [SW-1:0] last_sel;
  logic [31:0] mux_data;
  logic [SW-1:0] data_sel;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [SW-1:0] m_sel;
  logic        m_last;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int vectors;
  int miscompares;

  logic [31:0]   slice_val [16];
  logic [SW-1:0] mux_sel_q;

  gen_debug_data_sweep_capture #(
    .DATA_SEL_OPTIONS(N),
    .DATA_SEL_WIDTH(SW),
    .OUT_DATA_BUS_WIDTH(32),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .first_sel(first_sel),
    .last_sel(last_sel),
    .mux_data(mux_data),
    .data_sel(data_sel),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_sel(m_sel),
    .m_last(m_last),
    .busy(busy),
    .done(done),
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Debug mux model: select register, then data register.
  always @(posedge clk) begin
    mux_sel_q <= data_sel;
    mux_data  <= slice_val[mux_sel_q];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!m_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_valid", m_valid, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, m_valid, 1'b0);
    chk({tag, "_data"}, m_data, 32'h0);
    chk({tag, "_sel"}, m_sel, 0);
    chk({tag, "_last"}, m_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_cfg_err"}, cfg_err, 1'b0);
    chk({tag, "_data_sel"}, data_sel, 0);
  endtask

  // One complete sweep: expected sequence from ((last-first) mod N)+1.
  task automatic do_sweep(input int first, input int last, input int stall_word,
                          input int stall_len, input bit rand_ready, input bit inject);
    int exp_q[$];
    int n;
    int cyc;
    int k;
    logic [31:0] hold;
    n = ((last - first + N) % N) + 1;
    for (int j = 0; j < n; j++) exp_q.push_back((first + j) % N);

    first_sel = SW'(first);
    last_sel  = SW'(last);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1'b1);

    for (int i = 0; i < n; i++) begin
      cyc = 0;
      while (!m_valid && cyc < 40) begin
        chk("settle_data_sel", data_sel, exp_q[i]);
        chk("settle_cfg_err", cfg_err, 1'b0);
        if (inject && i == 0 && cyc == 1) begin
          start     = 1'b1;
          first_sel = SW'(7);
          last_sel  = SW'(15);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
      start     = 1'b0;
      first_sel = SW'(first);
      last_sel  = SW'(last);
      chk("word_valid", m_valid, 1'b1);
      chk("settle_gap", cyc, SETTLE);
      chk("word_data", m_data, slice_val[exp_q[i]]);
      chk("word_sel", m_sel, exp_q[i]);
      chk("word_last", m_last, (i == n - 1));
      chk("word_busy", busy, 1'b1);

      if (i == stall_word) k = stall_len;
      else if (rand_ready) k = $urandom_range(0, 3);
      else k = 0;
      hold = m_data;
      for (int s = 0; s < k; s++) begin
        @(negedge clk);
        chk("stall_valid", m_valid, 1'b1);
        chk("stall_data", m_data, hold);
        chk("stall_sel", m_sel, exp_q[i]);
        chk("stall_data_sel", data_sel, exp_q[i]);
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      chk("post_xfer_valid", m_valid, 1'b0);
      if (i == n - 1) begin
        chk("done_pulse", done, 1'b1);
        chk("end_busy", busy, 1'b0);
        @(negedge clk);
        chk("done_clear", done, 1'b0);
      end else begin
        chk("no_early_done", done, 1'b0);
      end
    end
  endtask

  initial begin
    int cyc;
    logic [SW-1:0] ds;
    vectors     = 0;
    miscompares = 0;
    for (int k = 0; k < 16; k++) slice_val[k] = 32'hA000_0000 | k;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    first_sel = '0;
    last_sel  = '0;
    m_ready   = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Basic, wrapped and single-word sweeps with ready held high.
    do_sweep(0, 3, -1, 0, 1'b0, 1'b0);
    do_sweep(10, 1, -1, 0, 1'b0, 1'b0);
    do_sweep(5, 5, -1, 0, 1'b0, 1'b0);
    chk("idle_hold_sel", data_sel, 5);

    // Long stall on the second word, plus a start issued while busy.
    do_sweep(0, 3, 1, 6, 1'b0, 1'b1);

    // Out-of-range starts.
    ds = data_sel;
    first_sel = SW'(12);
    last_sel  = SW'(3);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bad_first_cfg_err", cfg_err, 1'b1);
    chk("bad_first_busy", busy, 1'b0);
    chk("bad_first_data_sel", data_sel, ds);
    @(negedge clk);
    chk("bad_first_cfg_clear", cfg_err, 1'b0);
    chk("bad_first_busy2", busy, 1'b0);
    first_sel = SW'(2);
    last_sel  = SW'(15);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bad_last_cfg_err", cfg_err, 1'b1);
    chk("bad_last_busy", busy, 1'b0);

    // Abort during the settle of the second word.
    first_sel = SW'(0);
    last_sel  = SW'(3);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(cyc);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", m_valid, 1'b0);
    chk("abort_data_sel", data_sel, 1);
    chk("abort_last", m_last, 1'b0);
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
      chk("abort_idle_valid", m_valid, 1'b0);
    end
    do_sweep(2, 4, -1, 0, 1'b0, 1'b0);

    // Abort and a valid start together: nothing starts.
    first_sel = SW'(0);
    last_sel  = SW'(0);
    start     = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", busy, 1'b0);
    chk("abort_start_cfg_err", cfg_err, 1'b0);
    @(negedge clk);
    chk("abort_start_busy2", busy, 1'b0);

    // Asynchronous reset while a word is waiting in SEND.
    first_sel = SW'(6);
    last_sel  = SW'(9);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(cyc);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_sweep(0, 3, -1, 0, 1'b0, 1'b0);

    // Randomized sweeps with random slice contents and ready stalls.
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < N; k++) slice_val[k] = $urandom;
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        ds = data_sel;
        first_sel = SW'($urandom_range(N, 15));
        last_sel  = SW'($urandom_range(0, 15));
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rand_cfg_err", cfg_err, 1'b1);
        chk("rand_cfg_data_sel", data_sel, ds);
      end
      do_sweep($urandom_range(0, N - 1), $urandom_range(0, N - 1), -1, 0, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
